// File: rtl/sift_desc_pkg.sv
// -----------------------------------------------------------------------------
// sift_desc_pkg
// Shared constants and types for the SIFT descriptor orientation stages.
//   NBIN        : number of orientation bins (16)
//   CNT_DW_DEF  : default width of a histogram bin / histogram total
//   DW_DEF      : default width of one gradient magnitude sample
//   state_e     : orient_hist control states
//   dir_slot()  : maps bin k to its slice index in the packed dir bus
// -----------------------------------------------------------------------------
package sift_desc_pkg;

   localparam int NBIN       = 16;
   localparam int CNT_DW_DEF = 16;
   localparam int DW_DEF     = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      SCAN = 2'd2,
      EMIT = 2'd3
   } state_e;

   // Bin k lives in dir slice (k+8) mod 16; the 4-bit add wraps naturally.
   function automatic logic [3:0] dir_slot(input logic [3:0] k);
      return k + 4'd8;
   endfunction

endpackage

// File: rtl/sat_add.sv
// -----------------------------------------------------------------------------
// sat_add
// Saturating unsigned adder: y = min(a + b, 2^A_DW - 1).
//   a_i : A_DW-bit accumulator value
//   b_i : B_DW-bit increment (B_DW <= A_DW)
//   y_o : A_DW-bit saturated sum
// -----------------------------------------------------------------------------
module sat_add #(
   parameter int A_DW = 16,
   parameter int B_DW = 8
) (
   input  logic [A_DW-1:0] a_i,
   input  logic [B_DW-1:0] b_i,
   output logic [A_DW-1:0] y_o
);

   logic [A_DW:0] full;

   always_comb begin
      full = {1'b0, a_i} + {{(A_DW + 1 - B_DW){1'b0}}, b_i};
      y_o  = full[A_DW] ? {A_DW{1'b1}} : full[A_DW-1:0];
   end

endmodule

// File: rtl/orient_hist.sv
// -----------------------------------------------------------------------------
// orient_hist
// Builds a 16-bin orientation histogram from (bin, magnitude) samples, finds
// the dominant bin with a 16-cycle sequential scan, and hands the histogram,
// its total and the dominant index to the rotate/normalise stage.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   start      : begin a new region (IDLE only)
//   valid_in   : sample strobe (ACC only)
//   last       : final sample of region, qualified by valid_in
//   ori_bin    : 4-bit orientation bin of sample
//   mag        : gradient magnitude of sample
//   busy       : high in ACC, SCAN, EMIT
//   valid_sort : one-cycle pulse, outputs below carry a new result
//   data_sort  : dominant bin index (rotation offset)
//   dir        : packed histogram, bin k in slice (k+8) mod 16
//   dir_add    : saturated histogram total, 1 when the total is zero
//
// Build option: define ORIENT_HIST_SMOOTH_EN to make the scan compare the
// circularly smoothed value (b[k-1] + 2*b[k] + b[k+1]) >> 2 instead of b[k].
// -----------------------------------------------------------------------------
module orient_hist
   import sift_desc_pkg::*;
#(
   parameter int CNT_DW = CNT_DW_DEF,
   parameter int MAG_DW = DW_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     valid_in,
   input  logic                     last,
   input  logic [3:0]               ori_bin,
   input  logic [MAG_DW-1:0]        mag,
   output logic                     busy,
   output logic                     valid_sort,
   output logic [3:0]               data_sort,
   output logic [NBIN*CNT_DW-1:0]   dir,
   output logic [CNT_DW-1:0]        dir_add
);

   state_e                 state_q, state_d;

   logic [CNT_DW-1:0]      bin_q   [NBIN];
   logic [CNT_DW-1:0]      bin_inc [NBIN];
   logic [CNT_DW-1:0]      sum_q, sum_inc;

   logic [3:0]             k_q;
   logic [3:0]             idx_q;
   logic [CNT_DW+1:0]      max_q;
   logic [CNT_DW+1:0]      cand;

   logic                   valid_q;
   logic [3:0]             data_q;
   logic [NBIN*CNT_DW-1:0] dir_q;
   logic [CNT_DW-1:0]      dir_add_q;
   logic [NBIN*CNT_DW-1:0] dir_pack;

   logic                   accept;
   logic                   clear;

   assign accept = (state_q == ACC) && valid_in;
   assign clear  = (state_q == IDLE) && start;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start)             state_d = ACC;
         ACC:  if (valid_in && last)  state_d = SCAN;
         SCAN: if (k_q == 4'd15)      state_d = EMIT;
         EMIT:                        state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

   // ---------------- accumulation ----------------
   // One adder per bin keeps the update path a plain register feedback, so
   // consecutive samples to the same bin always see the freshly written value.
   for (genvar gi = 0; gi < NBIN; gi++) begin : g_bin
      sat_add #(.A_DW(CNT_DW), .B_DW(MAG_DW)) u_bin_add (
         .a_i (bin_q[gi]),
         .b_i (mag),
         .y_o (bin_inc[gi])
      );

      localparam int SLOT = int'(dir_slot(4'(gi)));
      assign dir_pack[SLOT*CNT_DW +: CNT_DW] = bin_q[gi];
   end

   sat_add #(.A_DW(CNT_DW), .B_DW(MAG_DW)) u_sum_add (
      .a_i (sum_q),
      .b_i (mag),
      .y_o (sum_inc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NBIN; k++) bin_q[k] <= '0;
         sum_q <= '0;
      end else if (clear) begin
         for (int k = 0; k < NBIN; k++) bin_q[k] <= '0;
         sum_q <= '0;
      end else if (accept) begin
         for (int k = 0; k < NBIN; k++)
            if (ori_bin == 4'(k)) bin_q[k] <= bin_inc[k];
         sum_q <= sum_inc;
      end
   end

   // ---------------- dominant-bin scan ----------------
`ifdef ORIENT_HIST_SMOOTH_EN
   logic [3:0] k_prev, k_next;
   always_comb begin
      k_prev = k_q - 4'd1;
      k_next = k_q + 4'd1;
      cand   = ({2'b00, bin_q[k_prev]} + {1'b0, bin_q[k_q], 1'b0}
                + {2'b00, bin_q[k_next]}) >> 2;
   end
`else
   assign cand = {2'b00, bin_q[k_q]};
`endif

   // Max starts at zero and only a strictly greater value replaces it, so ties
   // keep the lowest index and an empty histogram reports bin 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_q   <= '0;
         idx_q <= '0;
         max_q <= '0;
      end else if (accept && last) begin
         k_q   <= '0;
         idx_q <= '0;
         max_q <= '0;
      end else if (state_q == SCAN) begin
         k_q <= k_q + 4'd1;
         if (cand > max_q) begin
            max_q <= cand;
            idx_q <= k_q;
         end
      end
   end

   // ---------------- result registers ----------------
   // Loaded only when leaving EMIT, so they hold until the next region's EMIT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q   <= 1'b0;
         data_q    <= '0;
         dir_q     <= '0;
         dir_add_q <= '0;
      end else begin
         valid_q <= 1'b0;
         if (state_q == EMIT) begin
            valid_q   <= 1'b1;
            data_q    <= idx_q;
            dir_q     <= dir_pack;
            dir_add_q <= (sum_q == '0) ? CNT_DW'(1) : sum_q;
         end
      end
   end

   assign valid_sort = valid_q;
   assign data_sort  = data_q;
   assign dir        = dir_q;
   assign dir_add    = dir_add_q;

endmodule

// File: tb/tb_orient_hist.sv
// -----------------------------------------------------------------------------
// tb_orient_hist
// Directed self-checking bench for orient_hist (CNT_DW=16, MAG_DW=8).
// -----------------------------------------------------------------------------
module tb_orient_hist;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         valid_in;
   logic         last;
   logic [3:0]   ori_bin;
   logic [7:0]   mag;
   logic         busy;
   logic         valid_sort;
   logic [3:0]   data_sort;
   logic [255:0] dir;
   logic [15:0]  dir_add;

   int checks = 0;
   int errors = 0;

   orient_hist #(.CNT_DW(16), .MAG_DW(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .valid_in   (valid_in),
      .last       (last),
      .ori_bin    (ori_bin),
      .mag        (mag),
      .busy       (busy),
      .valid_sort (valid_sort),
      .data_sort  (data_sort),
      .dir        (dir),
      .dir_add    (dir_add)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_region();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [3:0] b, input logic [7:0] m, input logic l);
      valid_in = 1'b1;
      ori_bin  = b;
      mag      = m;
      last     = l;
      tick();
      valid_in = 1'b0;
      last     = 1'b0;
      mag      = '0;
   endtask

   // Called right after the last sample was accepted; valid_sort must rise
   // exactly 17 edges later (18th cycle counting the accepting one).
   task automatic expect_result(input string name, input logic [3:0] e_ds,
                                input logic [255:0] e_dir, input logic [15:0] e_add,
                                input bit poke_start);
      logic exp_v;
      for (int i = 1; i <= 17; i++) begin
         start = poke_start && (i == 5);
         tick();
         start = 1'b0;
         exp_v = (i == 17);
         checks++;
         if (valid_sort !== exp_v) begin
            errors++;
            $display("FAIL %s latency cycle %0d: valid_sort=%b required %b", name, i, valid_sort, exp_v);
         end
      end
      checks++;
      if (data_sort !== e_ds) begin
         errors++;
         $display("FAIL %s data_sort: got %0d required %0d", name, data_sort, e_ds);
      end
      checks++;
      if (dir !== e_dir) begin
         errors++;
         $display("FAIL %s dir: got %h required %h", name, dir, e_dir);
      end
      checks++;
      if (dir_add !== e_add) begin
         errors++;
         $display("FAIL %s dir_add: got %0d required %0d", name, dir_add, e_add);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_after_emit: got %b required 0", name, busy);
      end
      $display("region %s: data_sort=%0d dir_add=%0d", name, data_sort, dir_add);
      tick();
      checks++;
      if (valid_sort !== 1'b0 || data_sort !== e_ds || dir_add !== e_add) begin
         errors++;
         $display("FAIL %s hold: valid_sort=%b data_sort=%0d dir_add=%0d required 0/%0d/%0d",
                  name, valid_sort, data_sort, dir_add, e_ds, e_add);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; valid_in = 1'b0; last = 1'b0; ori_bin = '0; mag = '0;
      #22;
      checks++;
      if (busy !== 1'b0 || valid_sort !== 1'b0 || data_sort !== 4'd0 || dir !== '0 || dir_add !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b valid=%b ds=%0d dir_add=%0d required all 0",
                  busy, valid_sort, data_sort, dir_add);
      end
      rst = 1'b1;
      tick();
      $display("reset released");
   endtask

   task automatic test_single();
      logic [255:0] e;
      e = '0;
      e[11*16 +: 16] = 16'd15;
      e[4*16 +: 16]  = 16'd7;
      begin_region();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_in_acc: got %b required 1", busy);
      end
      send(4'd3, 8'd10, 1'b0);
      send(4'd3, 8'd5, 1'b0);
      send(4'd12, 8'd7, 1'b1);
      expect_result("single", 4'd3, e, 16'd22, 1'b0);
   endtask

   task automatic test_tie();
      logic [255:0] e;
      e = '0;
      e[13*16 +: 16] = 16'd9;
      e[10*16 +: 16] = 16'd9;
      begin_region();
      send(4'd5, 8'd9, 1'b0);
      send(4'd2, 8'd9, 1'b1);
      expect_result("tie", 4'd2, e, 16'd18, 1'b0);
   endtask

   task automatic test_empty();
      logic [255:0] e;
      e = '0;
      begin_region();
      send(4'd7, 8'd0, 1'b1);
      expect_result("empty", 4'd0, e, 16'd1, 1'b0);
   endtask

   task automatic test_saturation();
      logic [255:0] e;
      e = '0;
      e[8*16 +: 16] = 16'hFFFF;
      begin_region();
      for (int i = 0; i < 299; i++) send(4'd0, 8'd255, 1'b0);
      send(4'd0, 8'd255, 1'b1);
      expect_result("saturation", 4'd0, e, 16'hFFFF, 1'b0);
   endtask

   task automatic test_smooth();
      logic [255:0] e;
      logic [3:0]   e_ds;
      e = '0;
      e[12*16 +: 16] = 16'd10;
      e[14*16 +: 16] = 16'd10;
      e[13*16 +: 16] = 16'd8;
`ifdef ORIENT_HIST_SMOOTH_EN
      e_ds = 4'd5;
`else
      e_ds = 4'd4;
`endif
      begin_region();
      send(4'd4, 8'd10, 1'b0);
      send(4'd6, 8'd10, 1'b0);
      send(4'd5, 8'd8, 1'b1);
      expect_result("smooth", e_ds, e, 16'd28, 1'b0);
   endtask

   task automatic test_control();
      logic [255:0] e;
      e = '0;
      e[1*16 +: 16] = 16'd50;
      e[9*16 +: 16] = 16'd4;
      // Sample while IDLE must be dropped.
      send(4'd1, 8'd50, 1'b0);
      begin_region();
      send(4'd9, 8'd20, 1'b0);
      begin_region();                 // start during ACC: no clear
      send(4'd9, 8'd30, 1'b0);
      last = 1'b1;                    // last without valid_in: no transition
      tick();
      last = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL last_without_valid: busy=%b required 1", busy);
      end
      send(4'd1, 8'd4, 1'b1);
      expect_result("control", 4'd9, e, 16'd54, 1'b1);
   endtask

   task automatic test_reset_mid();
      logic [255:0] e;
      bit seen;
      e = '0;
      e[6*16 +: 16] = 16'd33;
      begin_region();
      send(4'd2, 8'd100, 1'b0);
      send(4'd2, 8'd100, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || valid_sort !== 1'b0 || data_sort !== 4'd0 || dir !== '0 || dir_add !== 16'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs: busy=%b valid=%b ds=%0d dir_add=%0d required all 0",
                  busy, valid_sort, data_sort, dir_add);
      end
      tick();
      tick();
      rst = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (valid_sort !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL reset_mid_no_valid: valid_sort seen=1 required 0");
      end
      $display("reset mid-region: no result emitted check done");
      begin_region();
      send(4'd14, 8'd33, 1'b1);
      expect_result("after_reset", 4'd14, e, 16'd33, 1'b0);
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_empty();
      test_saturation();
      test_smooth();
      test_control();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/orient_hist.md
Name: orient_hist

Overview:
- Builds the 16-bin gradient-orientation histogram for one descriptor region from a stream of (bin, magnitude) samples.
- Finds the dominant orientation bin and computes the histogram total.
- Drives the sorted-histogram interface (valid_sort, data_sort, dir, dir_add) consumed by the descriptor rotate/normalise stage.
- It is the producer end of that interface. Each valid_sort pulse hands over one rotation offset, one histogram and one divisor.

Parameters:
- CNT_DW, 16, width of each histogram bin and of the total dir_add.
- MAG_DW, 8, width of one input gradient magnitude.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begins a new region; honoured only in IDLE.
- valid_in  input  1  sample strobe; honoured only in ACC.
- last  input  1  qualifies the final sample of a region; meaningful only with valid_in.
- ori_bin  input  4  orientation bin 0..15 of the sample.
- mag  input  MAG_DW  gradient magnitude of the sample.
- busy  output  1  high in ACC, SCAN and EMIT.
- valid_sort  output  1  one-cycle pulse: dir, dir_add and data_sort are valid.
- data_sort  output  4  index of the dominant bin (rotation offset).
- dir  output  16*CNT_DW  packed histogram.
- dir_add  output  CNT_DW  histogram total, used downstream as divisor.

Behaviour:
- Reset (rst low, asynchronous, any state): state goes to IDLE; all bins, the running sum and the scan registers clear. Outputs reset to busy=0, valid_sort=0, data_sort=0, dir=0, dir_add=0.
- IDLE: start=1 clears the 16 bins and the running sum, then goes to ACC next cycle. valid_in is ignored.
- ACC: on valid_in, bin[ori_bin] += mag, saturating at 2^CNT_DW-1. The running sum also += mag, saturating.
  - One sample is accepted per cycle; back-to-back samples to the same bin must accumulate correctly, with no lost updates.
  - valid_in && last: that sample is accumulated and the state goes to SCAN.
  - start is ignored. last without valid_in is ignored.
- SCAN: exactly 16 cycles. Index k=0..15 is compared sequentially against the running maximum. Replacement happens only on strictly greater, so ties resolve to the lowest index. An all-zero histogram yields data_sort=0.
- EMIT (1 cycle):
  - Register dir, dir_add and data_sort.
  - Pulse valid_sort in the following cycle, with the registers already holding the new values.
  - Return to IDLE.
- Packing: bin k occupies dir slice s=(k+8) mod 16, i.e. dir[(s+1)*CNT_DW-1 : s*CNT_DW]. Bins 0..7 therefore sit in the upper half and bins 8..15 in the lower half.
- Divisor guard: if the saturated sum is 0, dir_add=1. Otherwise dir_add is the saturated sum. Because the sum saturates, dir_add >= every bin always holds.
- Hold: dir, dir_add and data_sort stay stable from the valid_sort pulse until the next EMIT. The downstream stage samples data_sort for several cycles after the pulse.
- Latency: valid_sort is asserted 18 cycles after the cycle in which the last sample is accepted (1 to enter SCAN, 16 SCAN, 1 EMIT).
- Reset mid-region discards the partial histogram; no valid_sort is produced for it.

Optional Feature:
- Macro: ORIENT_HIST_SMOOTH_EN.
- Defined: SCAN compares a circularly smoothed value (bin[k-1] + 2*bin[k] + bin[k+1]) >> 2, computed in CNT_DW+2 bits with index wrap 15<->0.
  - The tie rule is unchanged.
  - dir remains the unsmoothed bins.
  - Latency is unchanged.
- Not defined: SCAN compares raw bin values.

Decomposition:
- Package sift_desc_pkg holds:
  - the bin count constant NBIN=16;
  - CNT_DW and DW defaults;
  - the state enum {IDLE, ACC, SCAN, EMIT};
  - the bin-to-dir-slot function (k+8) mod 16.
- Sub-module sat_add: parameterised saturating adder (a of CNT_DW bits plus b of MAG_DW bits gives a CNT_DW-bit result). It is instantiated for the bins and the running sum.

Test Plan:
- Single region: samples (bin 3, mag 10), (bin 3, mag 5), (bin 12, mag 7, last) -> 18 cycles later valid_sort=1 for one cycle; data_sort=3; bin3=15 in dir slot 11; bin12=7 in dir slot 4; dir_add=22.
- Tie: bin 5 mag 9, bin 2 mag 9 (last) -> data_sort=2, dir_add=18.
- Saturation: 300 samples of bin 0, mag 255 -> bin0=65535, dir_add=65535, data_sort=0.
- Empty region: start, then a single (bin 7, mag 0, last) -> data_sort=0, dir all zero, dir_add=1.
- Control robustness:
  - start pulsed during ACC and SCAN is ignored.
  - rst asserted mid-ACC: all outputs are 0 immediately and no valid_sort follows.
  - A fresh region after reset produces a correct result.
- SMOOTH_EN build: raw bins bin4=10, bin6=10, bin5=8 -> data_sort=5 (smoothed value 9); without the macro -> data_sort=4.
